// File: rtl/apb_alu_seq.sv
// apb_alu_seq: APB3 slave arithmetic accelerator.
// Operands A/B, CTRL (op, start, ie), STATUS (busy, done W1C, ovf, err),
// RES_LO/RES_HI. Add/sub complete in one cycle; multiply is a sequential
// shift-add taking DW cycles, LSB of B first.
// IRQ: registered level done & ie when APB_ALU_IRQ_EN is defined, else constant 0.
module apb_alu_seq #(
  parameter int DW = 8
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [7:0]    PADDR,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  output logic          IRQ
);

  localparam int CW = $clog2(DW);

  localparam logic [7:0] ADDR_A    = 8'h00;
  localparam logic [7:0] ADDR_B    = 8'h04;
  localparam logic [7:0] ADDR_CTRL = 8'h08;
  localparam logic [7:0] ADDR_STAT = 8'h0C;
  localparam logic [7:0] ADDR_LO   = 8'h10;
  localparam logic [7:0] ADDR_HI   = 8'h14;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]   reg_a, reg_b;
  logic [1:0]      op;
  logic            ie;
  logic            done, ovf, err;
  logic [DW-1:0]   res_lo, res_hi;

  // working copies taken at start; w_a doubles as the shifted multiplicand
  logic [1:0]      w_op;
  logic [2*DW-1:0] w_a;
  logic [DW-1:0]   w_b;
  logic [2*DW-1:0] acc;
  logic [CW-1:0]   cnt;

  logic            busy, complete;
  logic            hit_a, hit_b, hit_ctrl, hit_stat, hit_lo, hit_hi, mapped;
  logic            wr, wr_bad, wr_ok, start;
  logic [DW:0]     sum, diff;
  logic [2*DW-1:0] acc_nx;

  assign busy     = (state == S_EXEC);
  assign hit_a    = (PADDR == ADDR_A);
  assign hit_b    = (PADDR == ADDR_B);
  assign hit_ctrl = (PADDR == ADDR_CTRL);
  assign hit_stat = (PADDR == ADDR_STAT);
  assign hit_lo   = (PADDR == ADDR_LO);
  assign hit_hi   = (PADDR == ADDR_HI);
  assign mapped   = hit_a | hit_b | hit_ctrl | hit_stat | hit_lo | hit_hi;

  // rejected writes leave every register untouched
  assign wr      = PSEL & PENABLE & PWRITE;
  assign wr_bad  = ~mapped | hit_lo | hit_hi | (busy & (hit_a | hit_b | hit_ctrl));
  assign wr_ok   = wr & ~wr_bad;
  assign PSLVERR = wr & wr_bad;
  assign PREADY  = 1'b1;
  assign start   = wr_ok & hit_ctrl & PWDATA[4];

  assign sum    = {1'b0, w_a[DW-1:0]} + {1'b0, w_b};
  assign diff   = {1'b0, w_a[DW-1:0]} - {1'b0, w_b};
  assign acc_nx = w_b[0] ? (acc + w_a) : acc;

  // state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state; multiply stays in EXEC until the last iteration
  always_comb begin
    state_nx = state;
    complete = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_EXEC;
      S_EXEC: begin
        if (w_op != OP_MUL || cnt == '0) begin
          state_nx = S_IDLE;
          complete = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // register file, working registers and result capture
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      reg_a  <= '0;
      reg_b  <= '0;
      op     <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      w_op   <= '0;
      w_a    <= '0;
      w_b    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok & hit_a)    reg_a <= PWDATA;
      if (wr_ok & hit_b)    reg_b <= PWDATA;
      if (wr_ok & hit_ctrl) op    <= PWDATA[1:0];
      if (wr_ok & hit_stat & PWDATA[1]) done <= 1'b0;

      if (start) begin
        done <= 1'b0;
        ovf  <= 1'b0;
        err  <= 1'b0;
        w_op <= PWDATA[1:0];
        w_a  <= {{DW{1'b0}}, reg_a};
        w_b  <= reg_b;
        acc  <= '0;
        cnt  <= CW'(DW - 1);
      end

      if (busy && w_op == OP_MUL) begin
        acc <= acc_nx;
        w_a <= w_a << 1;
        w_b <= w_b >> 1;
        cnt <= cnt - 1'b1;
      end

      // placed after the W1C so completion wins on a shared edge
      if (complete) begin
        done <= 1'b1;
        case (w_op)
          OP_ADD: begin
            res_lo <= sum[DW-1:0];
            res_hi <= {{(DW-1){1'b0}}, sum[DW]};
            ovf    <= sum[DW];
          end
          OP_SUB: begin
            res_lo <= diff[DW-1:0];
            res_hi <= {{(DW-1){1'b0}}, diff[DW]};
            ovf    <= diff[DW];
          end
          OP_MUL: begin
            res_lo <= acc_nx[DW-1:0];
            res_hi <= acc_nx[2*DW-1:DW];
            ovf    <= |acc_nx[2*DW-1:DW];
          end
          default: err <= 1'b1;
        endcase
      end
    end
  end

`ifdef APB_ALU_IRQ_EN
  // interrupt enable bit and registered interrupt level
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ie  <= 1'b0;
      IRQ <= 1'b0;
    end else begin
      if (wr_ok & hit_ctrl) ie <= PWDATA[5];
      IRQ <= done & ie;
    end
  end
`else
  assign ie  = 1'b0;
  assign IRQ = 1'b0;
`endif

  // read mux; unmapped addresses return all ones
  always_comb begin
    PRDATA = '1;
    case (PADDR)
      ADDR_A:    PRDATA = reg_a;
      ADDR_B:    PRDATA = reg_b;
      ADDR_CTRL: begin
        PRDATA      = '0;
        PRDATA[1:0] = op;
        PRDATA[5]   = ie;
      end
      ADDR_STAT: begin
        PRDATA      = '0;
        PRDATA[3:0] = {err, ovf, done, busy};
      end
      ADDR_LO:   PRDATA = res_lo;
      ADDR_HI:   PRDATA = res_hi;
      default:   PRDATA = '1;
    endcase
  end

endmodule

// File: tb/tb_apb_alu_seq.sv
// Directed testbench for apb_alu_seq (DW = 8).
// IRQ expectations follow the APB_ALU_IRQ_EN macro of the build.
module tb_apb_alu_seq;

  localparam int DW = 8;

`ifdef APB_ALU_IRQ_EN
  localparam logic IRQ_ON   = 1'b1;
  localparam logic [7:0] IE_RD = 8'h20;
`else
  localparam logic IRQ_ON   = 1'b0;
  localparam logic [7:0] IE_RD = 8'h00;
`endif

  logic          pclk;
  logic          preset;
  logic          psel, penable, pwrite;
  logic [7:0]    paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr, irq;

  int n_total = 0;
  int n_pass  = 0;

  apb_alu_seq #(.DW(DW)) dut (
    .PCLK    (pclk),
    .PRESET  (preset),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .IRQ     (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // combinational look at PRDATA without an APB transfer
  task peek(input logic [7:0] addr, output logic [DW-1:0] data);
    paddr = addr;
    #1;
    data = prdata;
  endtask

  task apb_write(input logic [7:0] addr, input logic [DW-1:0] data, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    err = pslverr;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task apb_read(input logic [7:0] addr, output logic [DW-1:0] data);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    data = prdata;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // counts cycles with busy set, starting at the negedge after the start edge
  task run_count(input string tag, output int n);
    logic [DW-1:0] st;
    logic idle_seen;
    n = 0;
    idle_seen = 1'b0;
    for (int i = 0; i < 64 && !idle_seen; i++) begin
      @(negedge pclk);
      peek(8'h0C, st);
      if (st[0]) n++;
      else idle_seen = 1'b1;
    end
    check({tag, "_timeout"}, {31'd0, idle_seen}, 32'd1);
  endtask

  logic [DW-1:0] d;
  logic          e;
  int            n;

  initial begin
    preset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

    // reset values
    #2;
    peek(8'h00, d); check("rst_a", d, 8'h00);
    peek(8'h08, d); check("rst_ctrl", d, 8'h00);
    peek(8'h0C, d); check("rst_status", d, 8'h00);
    peek(8'h10, d); check("rst_res_lo", d, 8'h00);
    peek(8'h20, d); check("rst_unmapped", d, 8'hFF);
    check("rst_irq", irq, 1'b0);
    check("pready", pready, 1'b1);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;

    // add 0xF0 + 0x20
    apb_write(8'h00, 8'hF0, e);
    apb_write(8'h04, 8'h20, e);
    apb_write(8'h08, 8'h10, e);
    check("add_start_err", e, 1'b0);
    run_count("add", n);
    check("add_busy_cycles", n, 1);
    peek(8'h10, d); check("add_lo", d, 8'h10);
    peek(8'h14, d); check("add_hi", d, 8'h01);
    peek(8'h0C, d); check("add_status", d, 8'h06);
    peek(8'h08, d); check("ctrl_start_reads0", d, 8'h00);

    // sub 0x10 - 0x20
    apb_write(8'h00, 8'h10, e);
    apb_write(8'h04, 8'h20, e);
    apb_write(8'h08, 8'h11, e);
    run_count("sub", n);
    check("sub_busy_cycles", n, 1);
    peek(8'h10, d); check("sub_lo", d, 8'hF0);
    peek(8'h14, d); check("sub_hi", d, 8'h01);
    peek(8'h0C, d); check("sub_status", d, 8'h06);

    // mul 0x0F * 0x11
    apb_write(8'h00, 8'h0F, e);
    apb_write(8'h04, 8'h11, e);
    apb_write(8'h08, 8'h12, e);
    run_count("mul1", n);
    check("mul1_busy_cycles", n, 8);
    peek(8'h10, d); check("mul1_lo", d, 8'hFF);
    peek(8'h14, d); check("mul1_hi", d, 8'h00);
    peek(8'h0C, d); check("mul1_status", d, 8'h02);
    peek(8'h08, d); check("mul1_ctrl", d, 8'h02);

    // mul 0xFF * 0xFF with accesses while busy
    apb_write(8'h00, 8'hFF, e);
    apb_write(8'h04, 8'hFF, e);
    apb_write(8'h08, 8'h12, e);
    apb_write(8'h00, 8'h55, e);
    check("busy_wr_a_err", e, 1'b1);
    apb_write(8'h08, 8'h11, e);
    check("busy_start_err", e, 1'b1);
    apb_read(8'h10, d);
    check("busy_rd_prev_lo", d, 8'hFF);
    apb_write(8'h10, 8'h33, e);
    check("busy_wr_lo_err", e, 1'b1);
    run_count("mul2", n);
    peek(8'h10, d); check("mul2_lo", d, 8'h01);
    peek(8'h14, d); check("mul2_hi", d, 8'hFE);
    peek(8'h0C, d); check("mul2_status", d, 8'h06);
    peek(8'h00, d); check("busy_a_unchanged", d, 8'hFF);
    peek(8'h08, d); check("busy_ctrl_unchanged", d, 8'h02);

    // W1C of done, bad writes
    apb_write(8'h0C, 8'h02, e);
    check("w1c_err", e, 1'b0);
    peek(8'h0C, d); check("w1c_status", d, 8'h04);
    apb_write(8'h18, 8'h01, e);
    check("unmapped_wr_err", e, 1'b1);
    apb_write(8'h14, 8'h01, e);
    check("wr_res_hi_err", e, 1'b1);
    peek(8'h14, d); check("res_hi_kept", d, 8'hFE);

    // reserved op 3
    apb_write(8'h08, 8'h13, e);
    run_count("op3", n);
    check("op3_busy_cycles", n, 1);
    peek(8'h0C, d); check("op3_status", d, 8'h0A);
    peek(8'h10, d); check("op3_lo_kept", d, 8'h01);
    peek(8'h14, d); check("op3_hi_kept", d, 8'hFE);

    // add with ie: IRQ one edge after done
    apb_write(8'h00, 8'h01, e);
    apb_write(8'h04, 8'h01, e);
    apb_write(8'h08, 8'h30, e);
    @(negedge pclk);
    @(negedge pclk);
    peek(8'h0C, d); check("irq_add_status", d, 8'h02);
    check("irq_before", irq, 1'b0);
    @(negedge pclk);
    check("irq_after", irq, IRQ_ON);
    peek(8'h08, d); check("ctrl_ie_rd", d, IE_RD);

    // mul 2*3 with W1C landing on the completion edge
    apb_write(8'h00, 8'h02, e);
    apb_write(8'h04, 8'h03, e);
    apb_write(8'h08, 8'h32, e);
    repeat (6) @(posedge pclk);
    apb_write(8'h0C, 8'h02, e);
    check("race_w1c_err", e, 1'b0);
    @(negedge pclk);
    peek(8'h0C, d); check("race_status", d, 8'h02);
    peek(8'h10, d); check("race_lo", d, 8'h06);
    @(negedge pclk);
    check("race_irq", irq, IRQ_ON);

    // reset pulse in the middle of a multiply
    apb_write(8'h00, 8'h0F, e);
    apb_write(8'h04, 8'h11, e);
    apb_write(8'h08, 8'h12, e);
    repeat (4) @(posedge pclk);
    #1 preset = 1'b1;
    #2 preset = 1'b0;
    @(negedge pclk);
    peek(8'h0C, d); check("abort_status", d, 8'h00);
    peek(8'h10, d); check("abort_lo", d, 8'h00);
    peek(8'h00, d); check("abort_a", d, 8'h00);
    check("abort_irq", irq, 1'b0);

    apb_write(8'h00, 8'h01, e);
    apb_write(8'h04, 8'h02, e);
    apb_write(8'h08, 8'h10, e);
    run_count("post_abort", n);
    peek(8'h10, d); check("post_abort_lo", d, 8'h03);

    // back-to-back: sub start on the edge after add completion
    apb_write(8'h08, 8'h10, e);
    apb_write(8'h08, 8'h11, e);
    check("b2b_err", e, 1'b0);
    run_count("b2b", n);
    peek(8'h10, d); check("b2b_lo", d, 8'hFF);
    peek(8'h14, d); check("b2b_hi", d, 8'h01);
    peek(8'h0C, d); check("b2b_status", d, 8'h06);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
